sao_stat_blk_scan: RTL and testbench

- Sequential successor to the combinational SAO-statistics boundary logic.
- On a start command, latches one CTU's position and picture geometry, then clips the per-component 2x2-block extent at the picture right/bottom edge.
- Scans components 0..NUM_COMP-1 in raster order of 2x2 blocks and emits one descriptor per block (X, Y, cIdx, availability flags) over a valid/ready handshake.
- Sits between the CTU controller and the SAO statistics accumulators.

---
 rtl/sao_scan_pkg.sv | 34 +++
 rtl/sao_blk_len_calc.sv | 26 ++
 rtl/sao_stat_blk_scan.sv | 219 +++++++++++++++++++++
 tb/tb_sao_stat_blk_scan.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sao_scan_pkg.sv
// rtl/sao_scan_pkg.sv - shared types, margins and block-bound arithmetic for the SAO block scanner
`timescale 1ns/1ps
package sao_scan_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, SCAN} scan_state_e;

  // Bound arithmetic width: max(PIC_W_LEN, PIC_H_LEN) + 1 for the default 13-bit geometry.
  localparam int CALC_W = 14;

  localparam int SKIP_X_L_DEF = 4;
  localparam int SKIP_Y_L_DEF = 3;
  localparam int SKIP_X_C_DEF = 3;
  localparam int SKIP_Y_C_DEF = 2;

  // Last 2x2-block index of one component along one axis, clipped at the picture edge.
  function automatic logic [4:0] calc_blk_len(
    input logic [CALC_W-1:0] dim,
    input logic [CALC_W-1:0] pos,
    input logic [2:0]        ctu_size,
    input logic              sh,
    input logic [CALC_W-1:0] skip
  );
    logic [CALC_W-1:0] cw;
    logic [CALC_W-1:0] rem;
    logic [CALC_W-1:0] ew;
    logic [CALC_W-1:0] nb;
    cw  = (CALC_W'(1) << ctu_size) >> sh;
    rem = (dim - (pos << ctu_size)) >> sh;
    ew  = (cw < rem) ? cw : rem;
    nb  = (ew + CALC_W'(1)) >> 1;
    return (nb > skip) ? 5'(nb - skip) : 5'd0;
  endfunction

endpackage

// File: rtl/sao_blk_len_calc.sv
// rtl/sao_blk_len_calc.sv - combinational per-component block bound for one axis
`timescale 1ns/1ps
module sao_blk_len_calc
  import sao_scan_pkg::*;
#(
  parameter int CHROMA_SHIFT = 1,
  parameter int SKIP_L       = 4,
  parameter int SKIP_C       = 3
) (
  input  logic [CALC_W-1:0] dim,
  input  logic [CALC_W-1:0] pos,
  input  logic [2:0]        ctu_size,
  input  logic              is_chroma,
  output logic [4:0]        len
);

  logic              sh;
  logic [CALC_W-1:0] skip;

  always_comb begin
    sh   = is_chroma && (CHROMA_SHIFT != 0);
    skip = is_chroma ? CALC_W'(SKIP_C) : CALC_W'(SKIP_L);
    len  = calc_blk_len(dim, pos, ctu_size, sh, skip);
  end

endmodule

// File: rtl/sao_stat_blk_scan.sv
// rtl/sao_stat_blk_scan.sv - per-CTU raster scan of 2x2 blocks emitting SAO statistics descriptors
`timescale 1ns/1ps
module sao_stat_blk_scan
  import sao_scan_pkg::*;
#(
  parameter int PIC_W_LEN    = 13,
  parameter int PIC_H_LEN    = 13,
  parameter int CTU_X_LEN    = 9,
  parameter int CTU_Y_LEN    = 9,
  parameter int BLK_X_LEN    = 6,
  parameter int BLK_Y_LEN    = 6,
  parameter int NUM_COMP     = 3,
  parameter int CHROMA_SHIFT = 1,
  parameter int SKIP_X_L     = SKIP_X_L_DEF,
  parameter int SKIP_Y_L     = SKIP_Y_L_DEF,
  parameter int SKIP_X_C     = SKIP_X_C_DEF,
  parameter int SKIP_Y_C     = SKIP_Y_C_DEF
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [PIC_W_LEN-1:0] pic_width,
  input  logic [PIC_H_LEN-1:0] pic_height,
  input  logic [CTU_X_LEN-1:0] ctu_x,
  input  logic [CTU_Y_LEN-1:0] ctu_y,
  input  logic [2:0]           ctu_size,
  output logic                 busy,
  output logic                 blk_valid,
  input  logic                 blk_ready,
  output logic [BLK_X_LEN-1:0] blk_X,
  output logic [BLK_Y_LEN-1:0] blk_Y,
  output logic [1:0]           blk_cIdx,
  output logic                 isLeftAvail,
  output logic                 isAboveAvail,
  output logic                 isLeftAboveAvail,
  output logic                 isLeftMergeAvail,
  output logic                 isUpperMergeAvail,
  output logic                 blk_last_comp,
  output logic                 blk_last_ctu,
  output logic                 ctu_done,
  output logic [4:0]           X_len,
  output logic [4:0]           Y_len
);

  scan_state_e          state_q, state_d;
  logic [PIC_W_LEN-1:0] pic_w_q, pic_w_d;
  logic [PIC_H_LEN-1:0] pic_h_q, pic_h_d;
  logic [CTU_X_LEN-1:0] ctu_x_q, ctu_x_d;
  logic [CTU_Y_LEN-1:0] ctu_y_q, ctu_y_d;
  logic [2:0]           ctu_size_q, ctu_size_d;
  logic [BLK_X_LEN-1:0] x_q, x_d;
  logic [BLK_Y_LEN-1:0] y_q, y_d;
  logic [1:0]           cidx_q, cidx_d;
  logic [4:0]           x_len_q, x_len_d;
  logic [4:0]           y_len_q, y_len_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [4:0]           calc_x_len;
  logic [4:0]           calc_y_len;
  logic                 is_chroma;
  logic                 at_x_end;
  logic                 at_y_end;
  logic                 last_comp;
  logic                 last_cidx;

  assign is_chroma = (cidx_q != 2'd0);

  // Bounds are evaluated from the latched geometry; only SETUP captures them.
  sao_blk_len_calc #(
    .CHROMA_SHIFT (CHROMA_SHIFT),
    .SKIP_L       (SKIP_X_L),
    .SKIP_C       (SKIP_X_C)
  ) u_len_x (
    .dim       (CALC_W'(pic_w_q)),
    .pos       (CALC_W'(ctu_x_q)),
    .ctu_size  (ctu_size_q),
    .is_chroma (is_chroma),
    .len       (calc_x_len)
  );

  sao_blk_len_calc #(
    .CHROMA_SHIFT (CHROMA_SHIFT),
    .SKIP_L       (SKIP_Y_L),
    .SKIP_C       (SKIP_Y_C)
  ) u_len_y (
    .dim       (CALC_W'(pic_h_q)),
    .pos       (CALC_W'(ctu_y_q)),
    .ctu_size  (ctu_size_q),
    .is_chroma (is_chroma),
    .len       (calc_y_len)
  );

  assign at_x_end  = (x_q == BLK_X_LEN'(x_len_q));
  assign at_y_end  = (y_q == BLK_Y_LEN'(y_len_q));
  assign last_comp = at_x_end && at_y_end;
  assign last_cidx = (cidx_q == 2'(NUM_COMP - 1));

  always_comb begin
    state_d    = state_q;
    pic_w_d    = pic_w_q;
    pic_h_d    = pic_h_q;
    ctu_x_d    = ctu_x_q;
    ctu_y_d    = ctu_y_q;
    ctu_size_d = ctu_size_q;
    x_d        = x_q;
    y_d        = y_q;
    cidx_d     = cidx_q;
    x_len_d    = x_len_q;
    y_len_d    = y_len_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          pic_w_d    = pic_width;
          pic_h_d    = pic_height;
          ctu_x_d    = ctu_x;
          ctu_y_d    = ctu_y;
          ctu_size_d = ctu_size;
          x_d        = '0;
          y_d        = '0;
          cidx_d     = 2'd0;
          busy_d     = 1'b1;
          state_d    = SETUP;
        end
      end
      SETUP: begin
        x_len_d = calc_x_len;
        y_len_d = calc_y_len;
        x_d     = '0;
        y_d     = '0;
        state_d = SCAN;
      end
      SCAN: begin
        if (blk_ready) begin
          if (!at_x_end) begin
            x_d = x_q + 1'b1;
          end else if (!at_y_end) begin
            x_d = '0;
            y_d = y_q + 1'b1;
          end else begin
            x_d = '0;
            y_d = '0;
            if (last_cidx) begin
              busy_d  = 1'b0;
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              cidx_d  = cidx_q + 2'd1;
              state_d = SETUP;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over start, transfers and completion alike.
    if (abort) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= IDLE;
      pic_w_q    <= '0;
      pic_h_q    <= '0;
      ctu_x_q    <= '0;
      ctu_y_q    <= '0;
      ctu_size_q <= '0;
      x_q        <= '0;
      y_q        <= '0;
      cidx_q     <= '0;
      x_len_q    <= '0;
      y_len_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pic_w_q    <= pic_w_d;
      pic_h_q    <= pic_h_d;
      ctu_x_q    <= ctu_x_d;
      ctu_y_q    <= ctu_y_d;
      ctu_size_q <= ctu_size_d;
      x_q        <= x_d;
      y_q        <= y_d;
      cidx_q     <= cidx_d;
      x_len_q    <= x_len_d;
      y_len_q    <= y_len_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign blk_valid = (state_q == SCAN);
  assign busy      = busy_q;
  assign ctu_done  = done_q;
  assign blk_X     = x_q;
  assign blk_Y     = y_q;
  assign blk_cIdx  = cidx_q;
  assign X_len     = x_len_q;
  assign Y_len     = y_len_q;

  // Flags are qualified by valid so that idle and reset present all-zero outputs.
  assign isLeftAvail       = blk_valid && !((x_q == '0) && (ctu_x_q == '0));
  assign isAboveAvail      = blk_valid && !((y_q == '0) && (ctu_y_q == '0));
  assign isLeftAboveAvail  = isLeftAvail && isAboveAvail;
  assign isLeftMergeAvail  = blk_valid && (ctu_x_q != '0);
  assign isUpperMergeAvail = blk_valid && (ctu_y_q != '0);
  assign blk_last_comp     = blk_valid && last_comp;
  assign blk_last_ctu      = blk_valid && last_comp && last_cidx;

endmodule

// File: tb/tb_sao_stat_blk_scan.sv
// tb/tb_sao_stat_blk_scan.sv - scoreboard bench for sao_stat_blk_scan against a geometry model
`timescale 1ns/1ps
module tb_sao_stat_blk_scan;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [12:0] pic_width = '0;
  logic [12:0] pic_height = '0;
  logic [8:0]  ctu_x = '0;
  logic [8:0]  ctu_y = '0;
  logic [2:0]  ctu_size = '0;
  logic        busy, blk_valid;
  logic        blk_ready = 1'b0;
  logic [5:0]  blk_X, blk_Y;
  logic [1:0]  blk_cIdx;
  logic        isLeftAvail, isAboveAvail, isLeftAboveAvail, isLeftMergeAvail, isUpperMergeAvail;
  logic        blk_last_comp, blk_last_ctu, ctu_done;
  logic [4:0]  X_len, Y_len;

  typedef struct packed {
    logic [5:0] x;
    logic [5:0] y;
    logic [1:0] c;
    logic       la, aa, laa, lm, um, lc, lt;
    logic [4:0] xl, yl;
  } desc_t;

  desc_t exp_q[$];
  int    n_cmp = 0;
  int    n_fail = 0;
  int    n_xfer = 0;
  int    rmode = 0;
  int    seen_cnt[3];
  int    seen_xl[3];
  int    seen_yl[3];

  always #5 clk = ~clk;

  sao_stat_blk_scan dut (
    .clk(clk), .arst_n(arst_n), .start(start), .abort(abort),
    .pic_width(pic_width), .pic_height(pic_height), .ctu_x(ctu_x), .ctu_y(ctu_y),
    .ctu_size(ctu_size), .busy(busy), .blk_valid(blk_valid), .blk_ready(blk_ready),
    .blk_X(blk_X), .blk_Y(blk_Y), .blk_cIdx(blk_cIdx),
    .isLeftAvail(isLeftAvail), .isAboveAvail(isAboveAvail), .isLeftAboveAvail(isLeftAboveAvail),
    .isLeftMergeAvail(isLeftMergeAvail), .isUpperMergeAvail(isUpperMergeAvail),
    .blk_last_comp(blk_last_comp), .blk_last_ctu(blk_last_ctu), .ctu_done(ctu_done),
    .X_len(X_len), .Y_len(Y_len)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Last block index along one axis: component extent clipped at the edge, halved, minus margin.
  function automatic int blen(int dim, int pos, int sz, int c, bit is_x);
    int sh, skip, cw, rem, ew, nb;
    sh   = (c != 0) ? 1 : 0;
    skip = is_x ? ((c != 0) ? 3 : 4) : ((c != 0) ? 2 : 3);
    cw   = (1 << sz) >> sh;
    rem  = (dim - pos * (1 << sz)) >> sh;
    ew   = (cw < rem) ? cw : rem;
    nb   = (ew + 1) / 2;
    return (nb > skip) ? nb - skip : 0;
  endfunction

  task automatic build_exp(int pw, int ph, int cx, int cy, int sz);
    for (int c = 0; c < 3; c++) begin
      int xl, yl;
      xl = blen(pw, cx, sz, c, 1'b1);
      yl = blen(ph, cy, sz, c, 1'b0);
      for (int y = 0; y <= yl; y++) begin
        for (int x = 0; x <= xl; x++) begin
          desc_t d;
          d.x   = 6'(x);
          d.y   = 6'(y);
          d.c   = 2'(c);
          d.la  = (x != 0) || (cx != 0);
          d.aa  = (y != 0) || (cy != 0);
          d.laa = d.la && d.aa;
          d.lm  = (cx != 0);
          d.um  = (cy != 0);
          d.lc  = (x == xl) && (y == yl);
          d.lt  = d.lc && (c == 2);
          d.xl  = 5'(xl);
          d.yl  = 5'(yl);
          exp_q.push_back(d);
        end
      end
    end
  endtask

  function automatic desc_t sample();
    desc_t d;
    d = {blk_X, blk_Y, blk_cIdx, isLeftAvail, isAboveAvail, isLeftAboveAvail,
         isLeftMergeAvail, isUpperMergeAvail, blk_last_comp, blk_last_ctu, X_len, Y_len};
    return d;
  endfunction

  function automatic logic [33:0] all_outs();
    return {busy, blk_valid, blk_X, blk_Y, blk_cIdx, isLeftAvail, isAboveAvail,
            isLeftAboveAvail, isLeftMergeAvail, isUpperMergeAvail, blk_last_comp,
            blk_last_ctu, ctu_done, X_len, Y_len};
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0:       blk_ready = 1'b1;
        1:       blk_ready = !blk_ready;
        default: blk_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops one expected descriptor per accepted transfer and checks stall/bubble/done rules.
  initial begin
    desc_t cur, exp, p_desc;
    bit    p_stall, p_lc, p_lt, p_abort, lc_n, lt_n;
    p_stall = 0; p_lc = 0; p_lt = 0; p_abort = 0; p_desc = '0;
    forever begin
      @(negedge clk);
      cur = sample();
      if (!arst_n) begin
        exp_q.delete();
        p_stall = 0; p_lc = 0; p_lt = 0; p_abort = 0;
      end else begin
        if (p_abort) begin
          chk("abort_flush", longint'({blk_valid, busy, ctu_done}), 0);
        end else begin
          if (p_lt) chk("ctu_done_pulse", longint'({ctu_done, busy, blk_valid}), 4);
          else if (ctu_done) chk("spurious_done", longint'(ctu_done), 0);
          if (p_stall) chk("stall_hold", longint'({blk_valid, cur}), longint'({1'b1, p_desc}));
          if (p_lc && !p_lt) chk("comp_bubble", longint'(blk_valid), 0);
        end
        lc_n = 0;
        lt_n = 0;
        if (abort) begin
          exp_q.delete();
        end else if (blk_valid && blk_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL desc_unexpected: got 0x%0h, want no descriptor at %0t", cur, $time);
          end else begin
            exp = exp_q.pop_front();
            chk("desc", longint'(cur), longint'(exp));
          end
          if (cur.x == 0 && cur.y == 0) begin
            seen_xl[cur.c] = int'(cur.xl);
            seen_yl[cur.c] = int'(cur.yl);
          end
          seen_cnt[cur.c]++;
          n_xfer++;
          lc_n = cur.lc;
          lt_n = cur.lt;
        end
        p_lc    = lc_n;
        p_lt    = lt_n;
        p_stall = blk_valid && !blk_ready && !abort;
        p_desc  = cur;
        p_abort = abort;
      end
    end
  end

  task automatic set_geom(int pw, int ph, int cx, int cy, int sz);
    pic_width  = 13'(pw);
    pic_height = 13'(ph);
    ctu_x      = 9'(cx);
    ctu_y      = 9'(cy);
    ctu_size   = 3'(sz);
  endtask

  task automatic clear_seen();
    for (int c = 0; c < 3; c++) begin
      seen_cnt[c] = 0;
      seen_xl[c]  = -1;
      seen_yl[c]  = -1;
    end
  endtask

  task automatic wait_done(input string name);
    bit got;
    got = 0;
    for (int i = 0; i < 20000 && !got; i++) begin
      @(negedge clk);
      if (ctu_done) got = 1;
    end
    chk({name, "_reached"}, longint'(got), 1);
  endtask

  task automatic run_ctu(int pw, int ph, int cx, int cy, int sz, bit inject);
    build_exp(pw, ph, cx, cy, sz);
    clear_seen();
    @(posedge clk);
    #1;
    set_geom(pw, ph, cx, cy, sz);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (inject) begin
      repeat (30) @(posedge clk);
      #1;
      set_geom(int'($urandom_range(100, 4000)), int'($urandom_range(100, 4000)),
               int'($urandom_range(0, 5)), int'($urandom_range(0, 5)), 4);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    wait_done("ctu_done");
    chk("queue_drained", longint'(exp_q.size()), 0);
    exp_q.delete();
  endtask

  initial begin
    int base, pw, ph, sz, nw, nh, cx, cy;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", longint'(all_outs()), 0);
    @(posedge clk);
    #1;
    arst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", longint'(all_outs()), 0);

    // Interior CTU with a start pulse injected mid-scan.
    rmode = 0;
    run_ctu(1920, 1080, 3, 2, 6, 1'b1);
    chk("interior_luma_xlen", seen_xl[0], 28);
    chk("interior_luma_ylen", seen_yl[0], 29);
    chk("interior_luma_count", seen_cnt[0], 870);

    // Top-left CTU.
    run_ctu(1920, 1080, 0, 0, 6, 1'b0);
    chk("tl_chroma_xlen", seen_xl[1], 13);
    chk("tl_chroma_ylen", seen_yl[2], 14);

    // Right-edge clip.
    run_ctu(1928, 1080, 30, 2, 6, 1'b0);
    chk("clip_luma_xlen", seen_xl[0], 0);
    chk("clip_chroma_xlen", seen_xl[1], 0);
    chk("clip_luma_count", seen_cnt[0], 30);

    // Alternating backpressure.
    rmode = 1;
    run_ctu(1920, 1080, 3, 2, 6, 1'b0);
    rmode = 0;

    // Abort while the 100th descriptor is presented.
    build_exp(1920, 1080, 3, 2, 6);
    @(posedge clk);
    #1;
    set_geom(1920, 1080, 3, 2, 6);
    start = 1'b1;
    base = n_xfer;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(posedge clk);
      if (n_xfer - base == 99) break;
    end
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort_at_100", n_xfer - base, 99);
    @(negedge clk);
    chk("abort_busy", longint'({busy, blk_valid}), 0);
    repeat (3) @(posedge clk);
    run_ctu(1920, 1080, 3, 2, 6, 1'b0);

    // Start in the ctu_done cycle, first valid two cycles later.
    build_exp(640, 480, 9, 7, 5);
    @(posedge clk);
    #1;
    set_geom(640, 480, 9, 7, 5);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("pre_done");
    build_exp(640, 480, 2, 3, 4);
    set_geom(640, 480, 2, 3, 4);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("done_cycle_start_setup", longint'({busy, blk_valid}), 2);
    @(negedge clk);
    chk("done_cycle_start_valid", longint'(blk_valid), 1);
    wait_done("post_done");
    chk("queue_drained_b2b", longint'(exp_q.size()), 0);
    exp_q.delete();

    // Random geometry under random backpressure.
    rmode = 2;
    for (int n = 0; n < 8; n++) begin
      sz = int'($urandom_range(4, 6));
      pw = int'($urandom_range(16, 8000));
      ph = int'($urandom_range(16, 8000));
      nw = (pw + (1 << sz) - 1) >> sz;
      nh = (ph + (1 << sz) - 1) >> sz;
      cx = ($urandom_range(0, 1) == 1) ? nw - 1 : int'($urandom_range(0, nw - 1));
      cy = ($urandom_range(0, 1) == 1) ? nh - 1 : int'($urandom_range(0, nh - 1));
      run_ctu(pw, ph, cx, cy, sz, 1'b0);
    end
    rmode = 0;

    // Asynchronous reset mid-scan.
    build_exp(1920, 1080, 3, 2, 6);
    @(posedge clk);
    #1;
    set_geom(1920, 1080, 3, 2, 6);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (50) @(posedge clk);
    #3;
    arst_n = 1'b0;
    #1;
    chk("async_reset_clear", longint'(all_outs()), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    arst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_async_reset", longint'(all_outs()), 0);
    run_ctu(1000, 700, 15, 10, 6, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
